// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: operand forwarding mux, RV32I branch compare,
// same-cycle PC redirect / IF-ID flush, stall watchdog FSM and saturating
// branch statistics counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned STALL_MAX = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            id_hold,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_rf,
  input  logic [XLEN-1:0] rs2_rf,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] ex_result,
  input  logic [1:0]      beqFA,
  input  logic [1:0]      beqFB,
  input  logic            stall_en_beq,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            if_id_flush,
  output logic            hazard_error,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_stall_cycles
);

  localparam logic [6:0]      OpBranch = 7'b1100011;
  localparam int unsigned     RunW     = $clog2(STALL_MAX + 2);
  localparam logic [RunW-1:0] RunSat   = RunW'(STALL_MAX + 1);
  localparam logic [RunW-1:0] RunMax   = RunW'(STALL_MAX);

  typedef enum logic {StIdle, StStalled} state_e;

  state_e          state_q, state_d;
  logic [RunW-1:0] stall_run_q, stall_run_d;
  logic            hazard_q, hazard_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

  logic            is_branch;
  logic            branch_stall;
  logic            resolve;
  logic            cond;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  assign is_branch    = id_valid & (opcode == OpBranch);
  assign branch_stall = is_branch & stall_en_beq;
  assign resolve      = is_branch & ~stall_en_beq & ~id_hold;

  // Forwarding muxes: 0 = register file, 1 = WB, 2 = MEM, 3 = EX.
  always_comb begin
    unique case (beqFA)
      2'd0:    op_a = rs1_rf;
      2'd1:    op_a = wb_data;
      2'd2:    op_a = mem_result;
      default: op_a = ex_result;
    endcase
    unique case (beqFB)
      2'd0:    op_b = rs2_rf;
      2'd1:    op_b = wb_data;
      2'd2:    op_b = mem_result;
      default: op_b = ex_result;
    endcase
  end

  // Branch condition by funct3; 010/011 are never taken.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = (op_a == op_b);
      3'b001:  cond = (op_a != op_b);
      3'b100:  cond = ($signed(op_a) < $signed(op_b));
      3'b101:  cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  cond = (op_a < op_b);
      3'b111:  cond = (op_a >= op_b);
      default: cond = 1'b0;
    endcase
  end

  // Redirect is gated off while reset is asserted; the target is always driven.
  assign branch_taken  = resolve & cond & rst_n;
  assign if_id_flush   = branch_taken;
  assign branch_target = pc + imm;

  // Stall-tracking FSM next state and sticky watchdog.
  always_comb begin
    state_d     = state_q;
    stall_run_d = stall_run_q;
    hazard_d    = hazard_q;
    unique case (state_q)
      StIdle: begin
        if (branch_stall) begin
          state_d     = StStalled;
          stall_run_d = RunW'(1);
        end
      end
      StStalled: begin
        if (branch_stall) begin
          stall_run_d = (stall_run_q == RunSat) ? stall_run_q : stall_run_q + RunW'(1);
        end else begin
          state_d     = StIdle;
          stall_run_d = '0;
        end
      end
      default: begin
        state_d     = StIdle;
        stall_run_d = '0;
      end
    endcase
    if (stall_run_d > RunMax) begin
      hazard_d = 1'b1;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    st_cnt_d = st_cnt_q;
    if (resolve && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (branch_taken && (tk_cnt_q != '1)) tk_cnt_d = tk_cnt_q + CNT_W'(1);
    if (branch_stall && (st_cnt_q != '1)) st_cnt_d = st_cnt_q + CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      stall_run_q <= '0;
      hazard_q    <= 1'b0;
      br_cnt_q    <= '0;
      tk_cnt_q    <= '0;
      st_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      stall_run_q <= stall_run_d;
      hazard_q    <= hazard_d;
      br_cnt_q    <= br_cnt_d;
      tk_cnt_q    <= tk_cnt_d;
      st_cnt_q    <= st_cnt_d;
    end
  end

  assign hazard_error      = hazard_q;
  assign stat_branches     = br_cnt_q;
  assign stat_taken        = tk_cnt_q;
  assign stat_stall_cycles = st_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. A second instance with 3-bit
// counters shares the stimulus so counter saturation is reachable.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_hold;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rs1_rf;
  logic [31:0] rs2_rf;
  logic [31:0] wb_data;
  logic [31:0] mem_result;
  logic [31:0] ex_result;
  logic [1:0]  beqFA;
  logic [1:0]  beqFB;
  logic        stall_en_beq;

  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_flush;
  logic        hazard_error;
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [31:0] stat_stall_cycles;

  logic        s_taken;
  logic [31:0] s_target;
  logic        s_flush;
  logic        s_hazard;
  logic [2:0]  s_branches;
  logic [2:0]  s_taken_cnt;
  logic [2:0]  s_stall_cnt;

  int n_tests;
  int n_fail;

  localparam logic [6:0] OpBranch = 7'b1100011;

  branch_resolve_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_valid          (id_valid),
    .id_hold           (id_hold),
    .opcode            (opcode),
    .funct3            (funct3),
    .pc                (pc),
    .imm               (imm),
    .rs1_rf            (rs1_rf),
    .rs2_rf            (rs2_rf),
    .wb_data           (wb_data),
    .mem_result        (mem_result),
    .ex_result         (ex_result),
    .beqFA             (beqFA),
    .beqFB             (beqFB),
    .stall_en_beq      (stall_en_beq),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .if_id_flush       (if_id_flush),
    .hazard_error      (hazard_error),
    .stat_branches     (stat_branches),
    .stat_taken        (stat_taken),
    .stat_stall_cycles (stat_stall_cycles)
  );

  branch_resolve_unit #(.CNT_W(3)) dut_sat (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_valid          (id_valid),
    .id_hold           (id_hold),
    .opcode            (opcode),
    .funct3            (funct3),
    .pc                (pc),
    .imm               (imm),
    .rs1_rf            (rs1_rf),
    .rs2_rf            (rs2_rf),
    .wb_data           (wb_data),
    .mem_result        (mem_result),
    .ex_result         (ex_result),
    .beqFA             (beqFA),
    .beqFB             (beqFB),
    .stall_en_beq      (stall_en_beq),
    .branch_taken      (s_taken),
    .branch_target     (s_target),
    .if_id_flush       (s_flush),
    .hazard_error      (s_hazard),
    .stat_branches     (s_branches),
    .stat_taken        (s_taken_cnt),
    .stat_stall_cycles (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 1 unit after that, well clear of the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    id_valid     = 1'b1;
    id_hold      = 1'b0;
    opcode       = OpBranch;
    funct3       = f3;
    rs1_rf       = a;
    rs2_rf       = b;
    beqFA        = 2'd0;
    beqFB        = 2'd0;
    stall_en_beq = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int br, input int tk, input int st);
    check({tag, "_branches"}, 64'(stat_branches), 64'(br));
    check({tag, "_taken"}, 64'(stat_taken), 64'(tk));
    check({tag, "_stalls"}, 64'(stat_stall_cycles), 64'(st));
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    wb_data    = '0;
    mem_result = '0;
    ex_result  = '0;
    set_br(3'b000, 32'd5, 32'd5);
    pc  = 32'h100;
    imm = 32'h20;
    #2;
    // Reset: redirect gated, target still combinational, state cleared.
    check("rst_taken", 64'(branch_taken), 64'd0);
    check("rst_flush", 64'(if_id_flush), 64'd0);
    check("rst_target", 64'(branch_target), 64'h120);
    check("rst_hazard", 64'(hazard_error), 64'd0);
    check_stats("rst", 0, 0, 0);
    tick();
    rst_n = 1'b1;
    #1;

    // beq 5,5
    check("beq_taken", 64'(branch_taken), 64'd1);
    check("beq_flush", 64'(if_id_flush), 64'd1);
    check("beq_target", 64'(branch_target), 64'h120);
    tick();
    check_stats("beq", 1, 1, 0);

    // bne with EX forwarding (7 vs 7), then MEM forwarding (8 vs 7)
    set_br(3'b001, 32'd0, 32'd7);
    beqFA = 2'd3;
    ex_result = 32'd7;
    #1 check("bne_ex", 64'(branch_taken), 64'd0);
    tick();
    beqFA = 2'd2;
    mem_result = 32'd8;
    #1 check("bne_mem", 64'(branch_taken), 64'd1);
    tick();
    check_stats("bne", 3, 2, 0);

    // Signed vs unsigned comparisons on 0xFFFFFFFF vs 1
    set_br(3'b100, 32'hFFFF_FFFF, 32'd1);
    #1 check("blt", 64'(branch_taken), 64'd1);
    tick();
    set_br(3'b110, 32'hFFFF_FFFF, 32'd1);
    #1 check("bltu", 64'(branch_taken), 64'd0);
    tick();
    set_br(3'b111, 32'hFFFF_FFFF, 32'd1);
    #1 check("bgeu", 64'(branch_taken), 64'd1);
    tick();
    set_br(3'b101, 32'hFFFF_FFFF, 32'd1);
    #1 check("bge", 64'(branch_taken), 64'd0);
    tick();
    set_br(3'b010, 32'd3, 32'd3);
    #1 check("f3_010", 64'(branch_taken), 64'd0);
    tick();
    // WB forwarding on operand B
    set_br(3'b000, 32'd9, 32'd0);
    beqFB = 2'd1;
    wb_data = 32'd9;
    #1 check("beq_wb", 64'(branch_taken), 64'd1);
    tick();
    check_stats("cmp", 9, 5, 0);

    // Non-branch opcode with stall flag: ignored
    set_br(3'b000, 32'd1, 32'd1);
    opcode = 7'b0110011;
    stall_en_beq = 1'b1;
    #1 check("nonbr_taken", 64'(branch_taken), 64'd0);
    tick();
    check_stats("nonbr", 9, 5, 0);

    // Two-cycle load-use stall then resolve
    set_br(3'b000, 32'd4, 32'd4);
    stall_en_beq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check("stall2_taken", 64'(branch_taken), 64'd0);
      tick();
    end
    stall_en_beq = 1'b0;
    #1 check("stall2_resolve", 64'(branch_taken), 64'd1);
    tick();
    check_stats("stall2", 10, 6, 2);
    check("stall2_hazard", 64'(hazard_error), 64'd0);

    // Three-cycle stall trips the watchdog
    stall_en_beq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall3_taken", 64'(branch_taken), 64'd0);
      tick();
    end
    check("stall3_hazard", 64'(hazard_error), 64'd1);
    stall_en_beq = 1'b0;
    #1 check("stall3_resolve", 64'(branch_taken), 64'd1);
    tick();
    id_valid = 1'b0;
    tick();
    check("hazard_sticky", 64'(hazard_error), 64'd1);
    check_stats("stall3", 11, 7, 5);

    // id_hold for 4 cycles, target wraps modulo 2^32
    set_br(3'b000, 32'd4, 32'd4);
    pc = 32'hFFFF_FFF0;
    imm = 32'h20;
    id_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("hold_taken", 64'(branch_taken), 64'd0);
      check("hold_target", 64'(branch_target), 64'h10);
      tick();
    end
    check_stats("hold_mid", 11, 7, 5);
    id_hold = 1'b0;
    #1 check("hold_resolve", 64'(branch_taken), 64'd1);
    tick();
    check_stats("hold", 12, 8, 5);

    // Narrow instance: 12 resolved / 8 taken saturate at 7; 5 stalls do not
    check("sat_branches", 64'(s_branches), 64'd7);
    check("sat_taken", 64'(s_taken_cnt), 64'd7);
    check("sat_stalls", 64'(s_stall_cnt), 64'd5);

    // Asynchronous reset while STALLED
    set_br(3'b000, 32'd4, 32'd4);
    stall_en_beq = 1'b1;
    tick();
    check_stats("prerst", 12, 8, 6);
    #2 rst_n = 1'b0;
    #1;
    check_stats("midrst", 0, 0, 0);
    check("midrst_hazard", 64'(hazard_error), 64'd0);
    check("midrst_sat_br", 64'(s_branches), 64'd0);
    stall_en_beq = 1'b0;
    #1 check("midrst_gate", 64'(branch_taken), 64'd0);
    check("midrst_flush", 64'(if_id_flush), 64'd0);
    tick();
    rst_n = 1'b1;
    // Fresh branch after release: two stalls must not trip the watchdog
    stall_en_beq = 1'b1;
    tick();
    tick();
    stall_en_beq = 1'b0;
    #1 check("post_resolve", 64'(branch_taken), 64'd1);
    tick();
    check_stats("post", 1, 1, 2);
    check("post_hazard", 64'(hazard_error), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
